// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
// Arbitration-mode constants, FSM state type and one-hot to index conversion.
package bus_arbiter_rr_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_N     = 32;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;

    // OR-reduction of set-bit indices; exact for one-hot or all-zero input.
    function automatic logic [4:0] onehot_to_index(input logic [MAX_N-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// The master side drives requests and hold; the slave side is the arbiter.
interface bus_arbiter_rr_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  breq;
    logic          bhold;
    logic [N-1:0]  bgnt;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          timeout;
    logic [IW-1:0] timeout_id;

    modport master (
        output breq, bhold,
        input  bgnt, grant_id, grant_valid, timeout, timeout_id
    );

    modport slave (
        input  breq, bhold,
        output bgnt, grant_id, grant_valid, timeout, timeout_id
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational rotating priority picker: the lowest set request at or above ptr wins,
// wrapping modulo N.
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] win_idx,
    output logic [N-1:0]         win_oh
);
    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  rot_idx;
    logic [SW-1:0]  sum;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        found   = |rot;
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = IW'(i);
        end
        // Undo the rotation: the index is taken relative to ptr, modulo N.
        sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (sum >= SW'(N)) sum = sum - SW'(N);
        win_idx = sum[IW-1:0];
        win_oh  = found ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with round-robin or fixed priority, registered one-hot grant,
// and a bus-hold tenure watchdog that revokes overlong holds.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N        = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input logic            clock,
    input logic            reset,
    bus_arbiter_rr_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX   = '1;

    arb_state_e    state, nxt_state;
    logic [N-1:0]  bgnt, nxt_bgnt;
    logic [IW-1:0] grant_id, nxt_grant_id;
    logic          grant_valid, nxt_grant_valid;
    logic          timeout, nxt_timeout;
    logic [IW-1:0] timeout_id, nxt_timeout_id;
    logic [IW-1:0] ptr, nxt_ptr;
    logic [CW-1:0] hold_cnt, nxt_hold_cnt;

    logic          owned, wd_fire, tenure_end;
    logic [N-1:0]  eligible;
    logic [IW-1:0] pick_ptr;
    logic          found;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;

    assign owned      = (state == ST_OWNED);
    assign wd_fire    = (MAX_HOLD > 0) && owned && bus.bhold && (hold_cnt == HOLD_LAST);
    assign tenure_end = owned && (!bus.bhold || wd_fire);
    // The finishing owner sits out one arbitration so it cannot immediately re-win.
    assign eligible   = bus.breq & (tenure_end ? ~bgnt : {N{1'b1}});
    assign pick_ptr   = (RR_MODE == ARB_RR) ? ptr : '0;

    rr_priority_picker #(.N(N)) u_picker (
        .req     (eligible),
        .ptr     (pick_ptr),
        .found   (found),
        .win_idx (win_idx),
        .win_oh  (win_oh)
    );

    always_comb begin
        nxt_state       = state;
        nxt_bgnt        = bgnt;
        nxt_grant_id    = grant_id;
        nxt_grant_valid = grant_valid;
        nxt_timeout     = 1'b0;
        nxt_timeout_id  = '0;
        nxt_ptr         = ptr;
        nxt_hold_cnt    = hold_cnt;
        if (!owned || tenure_end) begin
            nxt_hold_cnt = '0;
            if (found) begin
                nxt_state       = ST_OWNED;
                nxt_bgnt        = win_oh;
                nxt_grant_id    = IW'(onehot_to_index(MAX_N'(win_oh)));
                nxt_grant_valid = 1'b1;
                nxt_ptr         = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                nxt_state       = ST_IDLE;
                nxt_bgnt        = '0;
                nxt_grant_id    = '0;
                nxt_grant_valid = 1'b0;
            end
            if (wd_fire) begin
                nxt_timeout    = 1'b1;
                nxt_timeout_id = grant_id;
            end
        end else if (hold_cnt != CNT_MAX) begin
            nxt_hold_cnt = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bgnt        <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            timeout_id  <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= nxt_state;
            bgnt        <= nxt_bgnt;
            grant_id    <= nxt_grant_id;
            grant_valid <= nxt_grant_valid;
            timeout     <= nxt_timeout;
            timeout_id  <= nxt_timeout_id;
            ptr         <= nxt_ptr;
            hold_cnt    <= nxt_hold_cnt;
        end
    end

    assign bus.bgnt        = bgnt;
    assign bus.grant_id    = grant_id;
    assign bus.grant_valid = grant_valid;
    assign bus.timeout     = timeout;
    assign bus.timeout_id  = timeout_id;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a round-robin instance and a fixed-priority instance,
// N = 4, MAX_HOLD = 4, with hand-computed grant sequences and a short random soak.
module tb_bus_arbiter_rr;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    bus_arbiter_rr_if #(.N(4)) bus_rr ();
    bus_arbiter_rr_if #(.N(4)) bus_fx ();

    bus_arbiter_rr #(.N(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clock (clock),
        .reset (reset),
        .bus   (bus_rr)
    );

    bus_arbiter_rr #(.N(4), .RR_MODE(0), .MAX_HOLD(4)) u_fx (
        .clock (clock),
        .reset (reset),
        .bus   (bus_fx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_rr(input string tag, input logic [3:0] g, input logic [1:0] id);
        chk({tag, ".bgnt"}, 32'(bus_rr.bgnt), 32'(g));
        chk({tag, ".id"},   32'(bus_rr.grant_id), 32'(id));
        chk({tag, ".vld"},  32'(bus_rr.grant_valid), 32'(|g));
    endtask

    task automatic chk_to(input string tag, input logic to, input logic [1:0] id);
        chk({tag, ".timeout"},    32'(bus_rr.timeout), 32'(to));
        chk({tag, ".timeout_id"}, 32'(bus_rr.timeout_id), 32'(id));
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus_rr.breq   = '0;
        bus_rr.bhold  = 1'b0;
        bus_fx.breq   = '0;
        bus_fx.bhold  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_rr("rst", 4'b0000, 2'd0);
        chk_to("rst", 1'b0, 2'd0);
        reset = 1'b0;

        // Reset in the middle of a held tenure clears outputs immediately.
        bus_rr.breq  = 4'b0100;
        bus_rr.bhold = 1'b1;
        cyc(); chk_rr("own2", 4'b0100, 2'd2);
        cyc(); chk_rr("own2_hold", 4'b0100, 2'd2);
        #2 reset = 1'b1;
        #1 chk_rr("async_rst", 4'b0000, 2'd0);
        chk_to("async_rst", 1'b0, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        cyc(); chk_rr("post_rst", 4'b0100, 2'd2);

        // Sole requester alternates with an idle cycle.
        bus_rr.bhold = 1'b0;
        cyc(); chk_rr("sole_a", 4'b0000, 2'd0);
        cyc(); chk_rr("sole_b", 4'b0100, 2'd2);
        cyc(); chk_rr("sole_c", 4'b0000, 2'd0);
        cyc(); chk_rr("sole_d", 4'b0100, 2'd2);
        bus_rr.breq = 4'b0000;
        cyc(); chk_rr("sole_end", 4'b0000, 2'd0);

        // Fresh pointer, all requesting: strict rotation with no bubbles.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus_rr.breq = 4'b1111;
        cyc(); chk_rr("rr0", 4'b0001, 2'd0);
        cyc(); chk_rr("rr1", 4'b0010, 2'd1);
        cyc(); chk_rr("rr2", 4'b0100, 2'd2);
        cyc(); chk_rr("rr3", 4'b1000, 2'd3);
        cyc(); chk_rr("rr4", 4'b0001, 2'd0);
        bus_rr.breq = 4'b0000;
        cyc(); chk_rr("rr_idle", 4'b0000, 2'd0);

        // Watchdog: owner 1 holds past MAX_HOLD and is revoked; 3 takes over at once.
        bus_rr.breq  = 4'b0010;
        bus_rr.bhold = 1'b1;
        cyc(); chk_rr("wd_c1", 4'b0010, 2'd1);
        bus_rr.breq  = 4'b1010;
        cyc(); chk_rr("wd_c2", 4'b0010, 2'd1);
        cyc(); chk_rr("wd_c3", 4'b0010, 2'd1);
        cyc(); chk_rr("wd_c4", 4'b0010, 2'd1);
        chk_to("wd_c4", 1'b0, 2'd0);
        cyc(); chk_rr("wd_c5", 4'b1000, 2'd3);
        chk_to("wd_c5", 1'b1, 2'd1);
        cyc(); chk_rr("wd_c6", 4'b1000, 2'd3);
        chk_to("wd_c6", 1'b0, 2'd0);
        bus_rr.breq  = 4'b0000;
        bus_rr.bhold = 1'b0;
        cyc(); chk_rr("wd_end", 4'b0000, 2'd0);

        // Hold dropped exactly at the expiry cycle is a normal end, no timeout.
        bus_rr.breq  = 4'b0001;
        bus_rr.bhold = 1'b1;
        cyc(); chk_rr("nd_c1", 4'b0001, 2'd0);
        cyc(); cyc(); cyc(); chk_rr("nd_c4", 4'b0001, 2'd0);
        bus_rr.bhold = 1'b0;
        cyc(); chk_rr("nd_c5", 4'b0000, 2'd0);
        chk_to("nd_c5", 1'b0, 2'd0);
        cyc(); chk_rr("nd_c6", 4'b0001, 2'd0);
        bus_rr.breq = 4'b0000;
        cyc(); chk_rr("nd_end", 4'b0000, 2'd0);

        // Hold dominates a dropped request.
        bus_rr.breq  = 4'b0100;
        bus_rr.bhold = 1'b1;
        cyc(); chk_rr("hd_c1", 4'b0100, 2'd2);
        bus_rr.breq  = 4'b0000;
        cyc(); chk_rr("hd_c2", 4'b0100, 2'd2);
        cyc(); chk_rr("hd_c3", 4'b0100, 2'd2);
        bus_rr.bhold = 1'b0;
        cyc(); chk_rr("hd_end", 4'b0000, 2'd0);

        // Fixed priority: index 3 only wins while index 1 is masked.
        bus_fx.breq = 4'b1010;
        cyc(); chk("fx0", 32'(bus_fx.bgnt), 32'h2);
        cyc(); chk("fx1", 32'(bus_fx.bgnt), 32'h8);
        cyc(); chk("fx2", 32'(bus_fx.bgnt), 32'h2);
        cyc(); chk("fx3", 32'(bus_fx.bgnt), 32'h8);
        chk("fx3.id", 32'(bus_fx.grant_id), 32'd3);
        bus_fx.breq = 4'b0000;

        // Random soak: grant must stay one-hot-or-zero with a consistent valid flag.
        for (int i = 0; i < 200; i++) begin
            bus_rr.breq  = 4'($urandom);
            bus_rr.bhold = ($urandom_range(0, 3) != 0);
            cyc();
            chk("soak.onehot0", 32'($onehot0(bus_rr.bgnt)), 32'd1);
            chk("soak.vld", 32'(bus_rr.grant_valid), 32'(|bus_rr.bgnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
